// File: rtl/control_unit.sv
// control_unit -- multi-cycle sequencer for a tiny 8-bit accumulator machine.
//
// Each instruction is two bytes: an opcode byte (IR, opcode = IR[7:4], the low
// nibble is handed straight to the external ALU as alu_op) followed by an
// argument byte (ARG). The sequence is FETCH_OP -> FETCH_ARG -> DECODE -> EXEC,
// with an extra MEM_RD cycle for loads, and a terminal HALT state.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_addr/mem_rd     memory address and read strobe (data returns next cycle)
//   mem_rdata           read data from memory
//   mem_wr/mem_wdata    write strobe and write data (always ACC)
//   alu_op              ALU operation (IR[3:0])
//   operand_a/operand_b ALU operands (ACC / ARG)
//   alu_result, zero_flag, carry_flag, overflow_flag  combinational ALU outputs
//   pc, acc, flags      architectural state, flags = {V,C,Z}
//   halted              high only while in HALT
module control_unit (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic [3:0] alu_op,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  input  logic [7:0] alu_result,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       overflow_flag,
  output logic [7:0] pc,
  output logic [7:0] acc,
  output logic [2:0] flags,
  output logic       halted
);

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_ARG = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    MEM_RD    = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_CMP = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state;
  logic [7:0] ir;
  logic [7:0] arg;
  logic [3:0] opcode;

  assign opcode    = ir[7:4];
  assign alu_op    = ir[3:0];
  assign operand_a = acc;
  assign operand_b = arg;
  assign mem_wdata = acc;
  assign halted    = (state == HALT);

  // Memory strobes decode from the registered state. rst gates them
  // combinationally so an aborted ST can never reach memory.
  always_comb begin
    mem_addr = pc;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH_OP, FETCH_ARG: mem_rd = 1'b1;
        EXEC: begin
          if (opcode == OP_LD) begin
            mem_addr = arg;
            mem_rd   = 1'b1;
          end else if (opcode == OP_ST) begin
            mem_addr = arg;
            mem_wr   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OP;
      pc    <= 8'h00;
      acc   <= 8'h00;
      ir    <= 8'h00;
      arg   <= 8'h00;
      flags <= 3'b000;
    end else begin
      case (state)
        FETCH_OP: begin
          pc    <= pc + 8'd1;
          state <= FETCH_ARG;
        end
        // Opcode byte requested in FETCH_OP arrives now; PC wraps naturally
        // so an opcode at 0xFF takes its argument from 0x00.
        FETCH_ARG: begin
          ir    <= mem_rdata;
          pc    <= pc + 8'd1;
          state <= DECODE;
        end
        DECODE: begin
          arg   <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH_OP;
          case (opcode)
            OP_CMP: flags <= {overflow_flag, carry_flag, zero_flag};
            OP_LDI: acc <= arg;
            OP_LD:  state <= MEM_RD;
            OP_ST:  ;
            OP_JMP: pc <= arg;
            OP_JZ:  if (flags[0]) pc <= arg;
            OP_JC:  if (flags[1]) pc <= arg;
            OP_HLT: state <= HALT;
            // 0x0-0x7: arithmetic/logic through the external ALU
            default: begin
              acc   <= alu_result;
              flags <= {overflow_flag, carry_flag, zero_flag};
            end
          endcase
        end
        MEM_RD: begin
          acc   <= mem_rdata;
          state <= FETCH_OP;
        end
        HALT:    state <= HALT;
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural synchronous memory, behavioural ALU,
// and scoreboards of expected read addresses and expected writes.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [3:0] alu_op;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] alu_result;
  logic       zero_flag;
  logic       carry_flag;
  logic       overflow_flag;
  logic [7:0] pc;
  logic [7:0] acc;
  logic [2:0] flags;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_rd[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  e_rd;
  logic [15:0] e_wr;

  logic [7:0] mem [0:255];
  logic       clr;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  control_unit dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .alu_result(alu_result), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .pc(pc), .acc(acc), .flags(flags), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Reference ALU: ops 0-7, anything else yields zero with clear flags.
  always_comb begin
    logic [8:0] s;
    s             = 9'h000;
    alu_result    = 8'h00;
    carry_flag    = 1'b0;
    overflow_flag = 1'b0;
    zero_flag     = 1'b0;
    case (alu_op)
      4'h0: begin
        s = {1'b0, operand_a} + {1'b0, operand_b};
        alu_result    = s[7:0];
        carry_flag    = s[8];
        overflow_flag = (operand_a[7] == operand_b[7]) && (s[7] != operand_a[7]);
      end
      4'h1: begin
        s = {1'b0, operand_a} - {1'b0, operand_b};
        alu_result    = s[7:0];
        carry_flag    = s[8];
        overflow_flag = (operand_a[7] != operand_b[7]) && (s[7] != operand_a[7]);
      end
      4'h2: alu_result = operand_a & operand_b;
      4'h3: alu_result = operand_a | operand_b;
      4'h4: alu_result = operand_a ^ operand_b;
      4'h5: alu_result = ~operand_a;
      4'h6: begin alu_result = {operand_a[6:0], 1'b0}; carry_flag = operand_a[7]; end
      4'h7: begin alu_result = {1'b0, operand_a[7:1]}; carry_flag = operand_a[0]; end
      default: ;
    endcase
    if (alu_op < 4'h8) zero_flag = (alu_result == 8'h00);
  end

  // Scoreboard monitor: every read/write strobe must match the next expected entry.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      n_cmp++;
      if (mem_rd && mem_wr) begin
        n_bad++;
        $display("FAIL rd_wr_exclusive: got rd=1 wr=1, want at most one");
      end
    end
    if (mem_rd) begin
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_bad++;
        $display("FAIL read_addr: got unexpected read at %h, want no read", mem_addr);
      end else begin
        e_rd = exp_rd.pop_front();
        if (mem_addr !== e_rd) begin
          n_bad++;
          $display("FAIL read_addr: got %h, want %h", mem_addr, e_rd);
        end
      end
    end
    if (mem_wr) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL write: got unexpected write %h<=%h, want no write", mem_addr, mem_wdata);
      end else begin
        e_wr = exp_wr.pop_front();
        if ({mem_addr, mem_wdata} !== e_wr) begin
          n_bad++;
          $display("FAIL write: got %h<=%h, want %h<=%h", mem_addr, mem_wdata, e_wr[15:8], e_wr[7:0]);
        end
      end
    end
  end

  // Holds the DUT in reset and clears memory (two edges with rst=1).
  task automatic hold_reset();
    @(posedge clk); #1 rst = 1'b1; clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  task automatic push_reads(input int first, input int last);
    for (int i = first; i <= last; i++) exp_rd.push_back(8'(i));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_rd !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_rd: got %b, want 0", mem_rd); end
    n_cmp++; if (mem_wr !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_wr: got %b, want 0", mem_wr); end
    n_cmp++; if (pc !== 8'h00)      begin n_bad++; $display("FAIL reset_pc: got %h, want 00", pc); end
    n_cmp++; if (acc !== 8'h00)     begin n_bad++; $display("FAIL reset_acc: got %h, want 00", acc); end
    n_cmp++; if (flags !== 3'b000)  begin n_bad++; $display("FAIL reset_flags: got %b, want 000", flags); end
    n_cmp++; if (halted !== 1'b0)   begin n_bad++; $display("FAIL reset_halted: got %b, want 0", halted); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h, want 00", mem_addr); end
  endtask

  // LDI 0x7F; ADD 0x01; HLT
  task automatic test_add_overflow();
    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'h7F);
    poke(8'h02, 8'h00); poke(8'h03, 8'h01);
    poke(8'h04, 8'hF0); poke(8'h05, 8'h00);
    push_reads(0, 5);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (acc !== 8'h80)    begin n_bad++; $display("FAIL add_acc: got %h, want 80", acc); end
    n_cmp++; if (flags !== 3'b100) begin n_bad++; $display("FAIL add_flags: got %b, want 100", flags); end
    n_cmp++; if (pc !== 8'h04)     begin n_bad++; $display("FAIL add_pc: got %h, want 04", pc); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)  begin n_bad++; $display("FAIL add_halted: got %b, want 1", halted); end
    n_cmp++; if (pc !== 8'h06)     begin n_bad++; $display("FAIL add_halt_pc: got %h, want 06", pc); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL add_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
  endtask

  // LDI 0x05; SUB 0x05; JZ 0x20; (0x20) HLT
  task automatic test_jz_taken();
    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'h05);
    poke(8'h02, 8'h11); poke(8'h03, 8'h05);
    poke(8'h04, 8'hD0); poke(8'h05, 8'h20);
    poke(8'h20, 8'hF0); poke(8'h21, 8'h00);
    push_reads(0, 5); push_reads(8'h20, 8'h21);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (acc !== 8'h00)      begin n_bad++; $display("FAIL jz_acc: got %h, want 00", acc); end
    n_cmp++; if (flags !== 3'b001)   begin n_bad++; $display("FAIL jz_flags: got %b, want 001", flags); end
    n_cmp++; if (mem_addr !== 8'h20) begin n_bad++; $display("FAIL jz_fetch_addr: got %h, want 20", mem_addr); end
    n_cmp++; if (mem_rd !== 1'b1)    begin n_bad++; $display("FAIL jz_fetch_rd: got %b, want 1", mem_rd); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL jz_halted: got %b, want 1", halted); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL jz_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
  endtask

  // LDI 0x3C; ST 0x80; LDI 0x00; LD 0x80; HLT
  task automatic test_ld_st();
    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'h3C);
    poke(8'h02, 8'hB0); poke(8'h03, 8'h80);
    poke(8'h04, 8'h90); poke(8'h05, 8'h00);
    poke(8'h06, 8'hA0); poke(8'h07, 8'h80);
    poke(8'h08, 8'hF0); poke(8'h09, 8'h00);
    push_reads(0, 7); exp_rd.push_back(8'h80); push_reads(8, 9);
    exp_wr.push_back(16'h803C);
    rst = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (acc !== 8'h3C)      begin n_bad++; $display("FAIL ldst_acc: got %h, want 3C", acc); end
    n_cmp++; if (pc !== 8'h08)       begin n_bad++; $display("FAIL ldst_pc: got %h, want 08", pc); end
    n_cmp++; if (flags !== 3'b000)   begin n_bad++; $display("FAIL ldst_flags: got %b, want 000", flags); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL ldst_halted: got %b, want 1", halted); end
    n_cmp++; if (mem[8'h80] !== 8'h3C) begin n_bad++; $display("FAIL ldst_mem80: got %h, want 3C", mem[8'h80]); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL ldst_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
    n_cmp++; if (exp_wr.size() != 0) begin n_bad++; $display("FAIL ldst_writes_left: got %0d, want 0", exp_wr.size()); exp_wr.delete(); end
  endtask

  // LDI 0x10; CMP 0x10 (ALU op 0); JC 0x40 (not taken); HLT
  task automatic test_cmp_jc();
    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'h10);
    poke(8'h02, 8'h80); poke(8'h03, 8'h10);
    poke(8'h04, 8'hE0); poke(8'h05, 8'h40);
    poke(8'h06, 8'hF0); poke(8'h07, 8'h00);
    push_reads(0, 7);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (flags !== 3'b000)   begin n_bad++; $display("FAIL cmp_flags: got %b, want 000", flags); end
    n_cmp++; if (acc !== 8'h10)      begin n_bad++; $display("FAIL cmp_acc: got %h, want 10", acc); end
    n_cmp++; if (pc !== 8'h06)       begin n_bad++; $display("FAIL cmp_pc: got %h, want 06", pc); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL cmp_halted: got %b, want 1", halted); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL cmp_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
  endtask

  // LDI 0xFF; ADD 0x01 (C=1,Z=1); LDI 0x05 (flags kept); JC 0x10 (taken)
  task automatic test_flags_hold_jc();
    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'hFF);
    poke(8'h02, 8'h00); poke(8'h03, 8'h01);
    poke(8'h04, 8'h90); poke(8'h05, 8'h05);
    poke(8'h06, 8'hE0); poke(8'h07, 8'h10);
    poke(8'h10, 8'hF0); poke(8'h11, 8'h00);
    push_reads(0, 7); push_reads(8'h10, 8'h11);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (flags !== 3'b011)   begin n_bad++; $display("FAIL hold_flags: got %b, want 011", flags); end
    n_cmp++; if (acc !== 8'h05)      begin n_bad++; $display("FAIL hold_acc: got %h, want 05", acc); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pc !== 8'h10)       begin n_bad++; $display("FAIL jc_pc: got %h, want 10", pc); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL jc_halted: got %b, want 1", halted); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL jc_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
  endtask

  // JMP 0xFF; HLT at 0xFF takes its argument from 0x00
  task automatic test_wrap_halt();
    hold_reset();
    poke(8'h00, 8'hC0); poke(8'h01, 8'hFF);
    poke(8'hFF, 8'hF0);
    exp_rd.push_back(8'h00); exp_rd.push_back(8'h01);
    exp_rd.push_back(8'hFF); exp_rd.push_back(8'h00);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL wrap_halted: got %b, want 1", halted); end
    n_cmp++; if (pc !== 8'h01)       begin n_bad++; $display("FAIL wrap_pc: got %h, want 01", pc); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL wrap_still_halted: got %b, want 1", halted); end
    n_cmp++; if (pc !== 8'h01)       begin n_bad++; $display("FAIL wrap_pc_hold: got %h, want 01", pc); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL wrap_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
  endtask

  // Reset while halted, then reset in the EXEC cycle of a store.
  task automatic test_reset_abort();
    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'hAA);
    poke(8'h02, 8'hF0); poke(8'h03, 8'h00);
    push_reads(0, 3);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1)    begin n_bad++; $display("FAIL halt_setup: got %b, want 1", halted); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_rd !== 1'b0)    begin n_bad++; $display("FAIL halt_rst_rd: got %b, want 0", mem_rd); end
    @(posedge clk); #1 exp_rd.push_back(8'h00); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (halted !== 1'b0)    begin n_bad++; $display("FAIL halt_rst_halted: got %b, want 0", halted); end
    n_cmp++; if (acc !== 8'h00)      begin n_bad++; $display("FAIL halt_rst_acc: got %h, want 00", acc); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL halt_rst_fetch: got rd=%b addr=%h, want rd=1 addr=00", mem_rd, mem_addr); end
    @(posedge clk); #1 rst = 1'b1;

    hold_reset();
    poke(8'h00, 8'h90); poke(8'h01, 8'h3C);
    poke(8'h02, 8'hB0); poke(8'h03, 8'h80);
    push_reads(0, 3);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_wr !== 1'b0)    begin n_bad++; $display("FAIL st_rst_wr: got %b, want 0", mem_wr); end
    @(posedge clk); #1 exp_rd.push_back(8'h00); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (pc !== 8'h00)       begin n_bad++; $display("FAIL st_rst_pc: got %h, want 00", pc); end
    n_cmp++; if (acc !== 8'h00)      begin n_bad++; $display("FAIL st_rst_acc: got %h, want 00", acc); end
    n_cmp++; if (flags !== 3'b000)   begin n_bad++; $display("FAIL st_rst_flags: got %b, want 000", flags); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL st_rst_fetch: got rd=%b addr=%h, want rd=1 addr=00", mem_rd, mem_addr); end
    n_cmp++; if (mem[8'h80] !== 8'h00) begin n_bad++; $display("FAIL st_rst_mem80: got %h, want 00", mem[8'h80]); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL abort_reads_left: got %0d, want 0", exp_rd.size()); exp_rd.delete(); end
    n_cmp++; if (exp_wr.size() != 0) begin n_bad++; $display("FAIL abort_writes_left: got %0d, want 0", exp_wr.size()); exp_wr.delete(); end
  endtask

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    test_reset();
    test_add_overflow();
    test_jz_taken();
    test_ld_st();
    test_cmp_jc();
    test_flags_hold_jc();
    test_wrap_halt();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
